hac_drain: RTL
==============

# hac_drain

Result reader for the Hadamard accumulator (HAC). It waits for the accumulator's one-cycle done pulse and snapshots the full N×N complex accumulation into a shadow buffer. It then pulses `refresh` so the accumulator can start the next tile, and streams the snapshot out row-major over a valid/ready interface, LANES complex elements per beat. It sits between the HAC array and the inverse-FFT/write-back stage.

## Interface
- `N`, 16: tile dimension; the array is N×N.
- `LANES`, 4: complex elements per output beat; N % LANES == 0.
- `BEATS`, N*N/LANES (derived): beats per tile.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `acc_in`  in  complex [0:N-1][0:N-1]  accumulator result array; each element is 16-bit `.r` and 16-bit `.i` fixed-point.
- `acc_done`  in  1  one-cycle pulse from the accumulator; result valid and held.
- `refresh`  out  1  clears the accumulator and restarts its count.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accepts the beat.
- `m_data_r`  out  LANES*16  real parts; lane k at bits [k*16 +: 16].
- `m_data_i`  out  LANES*16  imaginary parts; same lane layout.
- `m_row`  out  clog2(N)  row index of the beat.
- `m_col`  out  clog2(N)  column of lane 0.
- `m_last`  out  1  high on the final beat of the tile.
- `tile_count`  out  16  number of tiles fully drained; wraps at 2^16.
- `overrun`  out  1  sticky error flag.

## Operation
- Registers: `state` (IDLE, DRAIN), `beat` [clog2(BEATS)], `pending`, shadow buffer (N×N×32 bits), `tile_count`, `overrun`.
- Values while reset is asserted, and immediately on assertion:
  - state=IDLE, beat=0, pending=0, m_valid=0, tile_count=0, overrun=0.
  - refresh=1.
- `refresh` deasserts at the first rising edge after reset releases. This first-edge clear starts the accumulator.
- IDLE, when `acc_done` or `pending` is high:
  - Copy all of `acc_in` into the shadow buffer at this edge.
  - refresh<=1 for exactly one cycle.
  - pending<=0, beat<=0, go to DRAIN.
- In all other cycles, refresh=0.
- DRAIN:
  - m_valid=1. Data, m_row, m_col and m_last come combinationally from shadow and `beat`.
  - m_row = beat / (N/LANES).
  - m_col = (beat % (N/LANES)) * LANES.
  - Lane k carries shadow[m_row][m_col+k].
  - On m_valid&m_ready: beat++.
  - If beat == BEATS-1: tile_count++, go to IDLE, m_valid falls the next cycle.
- `acc_done` while in DRAIN: pending<=1. If pending is already 1, overrun<=1 and the extra pulse is dropped.
  - Refresh is withheld while pending. The accumulator holds its result because it stops running after done.
- `acc_done` coinciding with the last handshake: sets pending. IDLE captures on the following edge, giving a one-cycle bubble.
- The shadow buffer is written only on capture. Changes to `acc_in` during DRAIN do not affect streamed data.
- `overrun` is cleared only by reset.

## Timing
- `acc_done` high in cycle t:
  - Capture at edge ending t.
  - refresh=1 and m_valid=1 in cycle t+1.
  - With m_ready held 1, beats occupy cycles t+1 .. t+BEATS, m_last in cycle t+BEATS.
  - m_valid=0 in t+BEATS+1.
- Backpressure:
  - While m_valid&!m_ready, all m_* outputs hold stable.
  - m_valid never drops mid-tile.
- Throughput: one tile per BEATS+1 cycles when pending drives back-to-back tiles.
- Reset mid-DRAIN: outputs go to reset values asynchronously. The partial tile is discarded and tile_count is not incremented.

## Test plan
- Reset:
  - During reset, refresh=1, m_valid=0, overrun=0, tile_count=0.
  - After release, refresh=0 from the second cycle on.
- Single tile, LANES=4, m_ready=1. Stimulus: acc_in[i][j].r=16i+j, .i=-(16i+j), acc_done at cycle t. Required:
  - refresh high in t+1 only.
  - 64 beats in t+1..t+64.
  - Beat 0: r lanes {0,1,2,3}, row 0, col 0.
  - Beat 5: row 1, col 4, r lanes {20..23}.
  - Beat 63: r lanes {252..255}, m_last=1.
  - tile_count=1.
- Backpressure: drop m_ready for 10 cycles at beat 5, then toggle it every cycle.
  - Beat 5 is held unchanged during the stall.
  - All 64 beats arrive in order, none lost or duplicated.
- Capture isolation: overwrite acc_in with all-0xFFFF the cycle after capture. The streamed values are still 16i+j.
- Deferred done: acc_done at beat 20 of tile A, with acc_in set to pattern B.
  - refresh stays 0 until A's last handshake.
  - One idle cycle follows.
  - Then refresh=1, B streams correctly, tile_count reaches 2.
- Overrun and mid-drain reset:
  - Two acc_done pulses during one DRAIN: overrun=1 and stays 1 after the tile completes.
  - Assert reset at beat 30: m_valid=0 immediately, overrun=0, refresh=1, tile_count unchanged from before the tile.

Source files
------------

// File: rtl/hac_drain_if.sv
// Complex element type shared by the HAC datapath, and the row-major
// valid/ready result stream leaving the drain stage.
package hac_drain_pkg;
    typedef struct packed {
        logic [15:0] r;
        logic [15:0] i;
    } complex_t;
endpackage

interface hac_drain_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 4
);
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned DATA_W = LANES * 16;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data_r;
    logic [DATA_W-1:0] m_data_i;
    logic [IDX_W-1:0]  m_row;
    logic [IDX_W-1:0]  m_col;
    logic              m_last;

    modport master (
        output m_valid, m_data_r, m_data_i, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data_r, m_data_i, m_row, m_col, m_last,
        output m_ready
    );
endinterface

// File: rtl/hac_drain.sv
// Snapshots the HAC's N x N result on acc_done, releases the accumulator via
// refresh, then streams the snapshot row-major LANES elements per beat.
module hac_drain
    import hac_drain_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  complex_t [0:N-1][0:N-1]      acc_in,
    input  logic                         acc_done,
    output logic                         refresh,
    hac_drain_if.master                  m,
    output logic [15:0]                  tile_count,
    output logic                         overrun
);
    localparam int unsigned BEATS  = N * N / LANES;
    localparam int unsigned CPR    = N / LANES;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned IDX_W  = $clog2(N);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     pending_q, pending_d;
    logic                     valid_q, valid_d;
    logic                     refresh_d;
    logic [15:0]              tile_count_d;
    logic                     overrun_d;
    logic                     capture;
    complex_t [0:N-1][0:N-1]  shadow_q;
    logic [IDX_W-1:0]         row_c;
    logic [IDX_W-1:0]         col_c;

    // State and control registers; refresh idles high in reset so the first
    // edge after release clears and starts the accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            pending_q  <= 1'b0;
            valid_q    <= 1'b0;
            refresh    <= 1'b1;
            tile_count <= '0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            refresh    <= refresh_d;
            tile_count <= tile_count_d;
            overrun    <= overrun_d;
        end
    end

    // Shadow buffer is written only on capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow_q <= acc_in;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        pending_d    = pending_q;
        valid_d      = valid_q;
        refresh_d    = 1'b0;
        tile_count_d = tile_count;
        overrun_d    = overrun;
        capture      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (acc_done || pending_q) begin
                    capture   = 1'b1;
                    refresh_d = 1'b1;
                    pending_d = 1'b0;
                    beat_d    = '0;
                    valid_d   = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                // A done during drain is deferred; a second one is lost.
                if (acc_done) begin
                    if (pending_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                if (valid_q && m.m_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        tile_count_d = tile_count + 16'd1;
                        beat_d       = '0;
                        valid_d      = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign row_c = IDX_W'(32'(beat_q) / CPR);
    assign col_c = IDX_W'((32'(beat_q) % CPR) * LANES);

    // Beat payload is a pure decode of the shadow and the beat counter, so it
    // holds stable under backpressure.
    always_comb begin
        m.m_data_r = '0;
        m.m_data_i = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            m.m_data_r[k*16 +: 16] = shadow_q[row_c][IDX_W'(32'(col_c) + k)].r;
            m.m_data_i[k*16 +: 16] = shadow_q[row_c][IDX_W'(32'(col_c) + k)].i;
        end
    end

    assign m.m_valid = valid_q;
    assign m.m_row   = row_c;
    assign m.m_col   = col_c;
    assign m.m_last  = valid_q && (beat_q == LAST_BEAT);

endmodule
